// File: rtl/uart_receiver_if.sv
// Receive-side byte stream of the UART receiver: a valid/ready byte channel
// plus the frame_error and overrun status pulses.
interface uart_receiver_if;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       frame_error;
    logic       overrun;

    modport master (
        output out_data,
        output out_valid,
        output frame_error,
        output overrun,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  frame_error,
        input  overrun,
        output out_ready
    );
endinterface

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: synchronizes uart_rx, recovers each byte by mid-bit sampling
// and hands it out through a one-entry valid/ready buffer.
module uart_receiver #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      uart_rx,
    uart_receiver_if.master bus
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam logic [15:0] HALF_TC = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] FULL_TC = 16'(CLKS_PER_BIT - 1);

    logic        rx_meta;
    logic        rx_s;
    logic        rx_d;
    logic        live_p0;
    logic        live_p1;
    logic        armed;
    state_t      state;
    logic [15:0] timer;
    logic [2:0]  index;
    logic [7:0]  shift;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta         <= 1'b1;
            rx_s            <= 1'b1;
            rx_d            <= 1'b1;
            live_p0         <= 1'b0;
            live_p1         <= 1'b0;
            armed           <= 1'b0;
            state           <= IDLE;
            timer           <= '0;
            index           <= '0;
            bus.out_data    <= '0;
            bus.out_valid   <= 1'b0;
            bus.frame_error <= 1'b0;
            bus.overrun     <= 1'b0;
        end else begin
            // Synchronizer stage boundary: rx_meta -> rx_s -> rx_d
            rx_meta <= uart_rx;
            rx_s    <= rx_meta;
            rx_d    <= rx_s;

            // rx_s only reflects the real line two cycles after reset; a start
            // edge is accepted only once the line has genuinely been seen high.
            live_p0 <= 1'b1;
            live_p1 <= live_p0;
            if (live_p1 && rx_s)
                armed <= 1'b1;

            bus.frame_error <= 1'b0;
            bus.overrun     <= 1'b0;
            if (bus.out_valid && bus.out_ready)
                bus.out_valid <= 1'b0;

            case (state)
                IDLE: begin
                    timer <= '0;
                    index <= '0;
                    if (armed && rx_d && !rx_s)
                        state <= START;
                end
                START: begin
                    if (timer == HALF_TC) begin
                        timer <= '0;
                        index <= '0;
                        state <= rx_s ? IDLE : DATA;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                DATA: begin
                    if (timer == FULL_TC) begin
                        timer        <= '0;
                        shift[index] <= rx_s;
                        index        <= index + 3'd1;
                        if (index == 3'd7)
                            state <= STOP;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                STOP: begin
                    if (timer == FULL_TC) begin
                        timer <= '0;
                        state <= IDLE;
                        if (!rx_s) begin
                            bus.frame_error <= 1'b1;
                        end else if (!bus.out_valid || bus.out_ready) begin
                            bus.out_data  <= shift;
                            bus.out_valid <= 1'b1;
                        end else begin
                            bus.overrun <= 1'b1;
                        end
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at 16 clocks per bit; received bytes are
// checked against a scoreboard queue filled when each frame is sent.
module tb_uart_receiver;

    localparam int CPB = 16;

    logic clk;
    logic reset;
    logic uart_rx;

    uart_receiver_if bus ();

    uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
        .clk     (clk),
        .reset   (reset),
        .uart_rx (uart_rx),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp    = 0;
    int n_fail   = 0;
    int fe_count = 0;
    int ov_count = 0;
    int hs_count = 0;
    logic [7:0] sb[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Handshakes pop the scoreboard; status pulses are counted per high cycle.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.frame_error) fe_count++;
            if (bus.overrun) ov_count++;
            if (bus.out_valid && bus.out_ready) begin
                hs_count++;
                n_cmp++;
                assert (sb.size() != 0) else begin
                    n_fail++;
                    $error("FAIL hs_unexpected: observed handshake data %0h, expected no handshake", bus.out_data);
                end
                if (sb.size() != 0) check("hs_data", 32'(bus.out_data), 32'(sb.pop_front()));
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic v, input int n);
        uart_rx = v;
        wait_cycles(n);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        send_bit(1'b0, CPB);
        for (int i = 0; i < 8; i++) send_bit(b[i], CPB);
        send_bit(stop, CPB);
    endtask

    initial begin
        reset = 1'b1;
        uart_rx = 1'b1;
        bus.out_ready = 1'b0;
        wait_cycles(3);
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_data", 32'(bus.out_data), 32'h00);
        check("rst_fe", 32'(bus.frame_error), 32'd0);
        check("rst_ov", 32'(bus.overrun), 32'd0);
        reset = 1'b0;
        wait_cycles(10);

        // Clean frame held with no consumer, then a single handshake
        sb.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        wait_cycles(4);
        check("a5_valid", 32'(bus.out_valid), 32'd1);
        check("a5_data", 32'(bus.out_data), 32'hA5);
        wait_cycles(50);
        check("a5_held_valid", 32'(bus.out_valid), 32'd1);
        check("a5_held_data", 32'(bus.out_data), 32'hA5);
        bus.out_ready = 1'b1;
        wait_cycles(1);
        bus.out_ready = 1'b0;
        check("a5_drained", 32'(bus.out_valid), 32'd0);
        check("a5_hs", 32'(hs_count), 32'd1);
        check("a5_fe", 32'(fe_count), 32'd0);

        // Glitch shorter than half a bit is rejected
        send_bit(1'b0, 4);
        send_bit(1'b1, 40);
        check("glitch_valid", 32'(bus.out_valid), 32'd0);
        check("glitch_fe", 32'(fe_count), 32'd0);
        check("glitch_idle", 32'(dut.state), 32'd0);
        bus.out_ready = 1'b1;
        sb.push_back(8'h3C);
        send_frame(8'h3C, 1'b1);
        wait_cycles(4);
        check("3c_hs", 32'(hs_count), 32'd2);
        bus.out_ready = 1'b0;

        // Stop bit low, then line held low
        send_frame(8'h3C, 1'b0);
        wait_cycles(4);
        check("fe_pulse", 32'(fe_count), 32'd1);
        check("fe_valid", 32'(bus.out_valid), 32'd0);
        wait_cycles(400);
        check("low_fe", 32'(fe_count), 32'd1);
        check("low_valid", 32'(bus.out_valid), 32'd0);
        send_bit(1'b1, 20);

        // Second byte overruns a full buffer
        sb.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        wait_cycles(4);
        check("ov_data", 32'(bus.out_data), 32'h11);
        check("ov_count", 32'(ov_count), 32'd1);
        check("ov_fe", 32'(fe_count), 32'd1);
        bus.out_ready = 1'b1;
        wait_cycles(3);
        check("ov_hs", 32'(hs_count), 32'd3);
        check("ov_drained", 32'(bus.out_valid), 32'd0);

        // Back-to-back frames with an always-ready consumer
        sb.push_back(8'h55);
        sb.push_back(8'hAA);
        send_frame(8'h55, 1'b1);
        send_frame(8'hAA, 1'b1);
        wait_cycles(4);
        check("b2b_hs", 32'(hs_count), 32'd5);
        check("b2b_ov", 32'(ov_count), 32'd1);
        bus.out_ready = 1'b0;

        // Reset during data bit 4, released with the line still low
        send_bit(1'b0, CPB);
        for (int i = 0; i < 4; i++) send_bit(i[0], CPB);
        send_bit(1'b0, 8);
        reset = 1'b1;
        wait_cycles(2);
        check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_data", 32'(bus.out_data), 32'h00);
        check("mid_rst_fe", 32'(bus.frame_error), 32'd0);
        check("mid_rst_ov", 32'(bus.overrun), 32'd0);
        reset = 1'b0;
        send_bit(1'b0, 200);
        send_bit(1'b1, 40);
        check("post_rst_idle", 32'(dut.state), 32'd0);
        check("post_rst_valid", 32'(bus.out_valid), 32'd0);
        check("post_rst_fe", 32'(fe_count), 32'd1);
        check("post_rst_ov", 32'(ov_count), 32'd1);
        sb.push_back(8'h7E);
        send_frame(8'h7E, 1'b1);
        wait_cycles(4);
        check("7e_valid", 32'(bus.out_valid), 32'd1);
        check("7e_data", 32'(bus.out_data), 32'h7E);
        bus.out_ready = 1'b1;
        wait_cycles(1);
        bus.out_ready = 1'b0;
        wait_cycles(2);
        check("7e_hs", 32'(hs_count), 32'd6);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, clk cycles per UART bit period (legal range 8..65535).
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 uart_rx  input  1  asynchronous serial line; idle high; 8N1 framing, LSB first.
REQ-005 out_data  output  8  received byte; stable while out_valid is high.
REQ-006 out_valid  output  1  out_data holds an unconsumed byte.
REQ-007 out_ready  input  1  consumer accepts out_data in any cycle where out_valid and out_ready are both high.
REQ-008 frame_error  output  1  one-cycle pulse: stop bit sampled low.
REQ-009 overrun  output  1  one-cycle pulse: completed byte dropped because buffer still full.

Function
REQ-010 uart_rx shall pass through a 2-flop synchronizer; all logic below uses the synchronized value rx_s and its one-cycle-delayed copy rx_d.
REQ-011 FSM states: IDLE, START, DATA, STOP; a 16-bit bit-timer and a 3-bit bit index are the only counters.
REQ-012 IDLE: on rx_d=1 and rx_s=0 (falling edge) -> START, timer cleared to 0; a line held low does not retrigger.
REQ-013 START: when timer reaches CLKS_PER_BIT/2-1 (integer division), sample rx_s; 0 -> DATA with timer and index cleared; 1 -> IDLE (glitch rejected, no output, no error).
REQ-014 DATA: when timer reaches CLKS_PER_BIT-1, sample rx_s into bit position index (LSB first), clear timer, increment index; after the sample at index 7 -> STOP.
REQ-015 STOP: when timer reaches CLKS_PER_BIT-1, sample rx_s; 1 -> commit byte, 0 -> pulse frame_error and discard byte; either case -> IDLE the next cycle.
REQ-016 Commit with buffer empty, or with out_ready high in the same cycle: out_data <= new byte, out_valid = 1 from next cycle.
REQ-017 Commit with out_valid=1 and out_ready=0: new byte dropped, out_data unchanged, overrun pulses for one cycle.
REQ-018 Handshake with no commit in the same cycle: out_valid = 0 next cycle; out_data retains last value.
REQ-019 out_valid, once high, shall not drop without a handshake; out_data shall not change while out_valid=1 except via REQ-016.
REQ-020 Latency: out_valid rises at most 9*CLKS_PER_BIT + CLKS_PER_BIT/2 + 4 cycles after the start-bit falling edge at uart_rx.
REQ-021 Timer shall never exceed CLKS_PER_BIT-1; no wrap-around path exists.
REQ-022 frame_error and overrun shall never both pulse for the same frame.

Reset
REQ-023 While reset=1: state IDLE, timer and index 0, synchronizer flops and rx_d set to 1, out_data 0x00, out_valid 0, frame_error 0, overrun 0.
REQ-024 Reset asserted mid-frame shall abandon the frame without pulsing any output; reception resumes only on the next falling edge after reset deasserts.
REQ-025 A line already low when reset deasserts shall not be taken as a start bit.

Verification (bench uses CLKS_PER_BIT=16)
REQ-026 Clean frame 0xA5, out_ready=0 -> out_valid=1, out_data=0xA5 held indefinitely, frame_error=0; out_ready=1 for one cycle -> out_valid=0 next cycle.
REQ-027 uart_rx low for 4 cycles then high -> no out_valid, no frame_error, FSM back in IDLE; following frame 0x3C received correctly.
REQ-028 Frame 0x3C with stop bit low -> frame_error single-cycle pulse, out_valid stays 0; line held low afterwards -> no further frames.
REQ-029 Frames 0x11 then 0x22 with out_ready=0 -> out_data=0x11, overrun pulses once at second stop-bit sample; then out_ready=1 -> one handshake, out_valid=0.
REQ-030 Back-to-back frames 0x55, 0xAA with out_ready=1 -> exactly two handshakes carrying 0x55 then 0xAA, no overrun.
REQ-031 reset pulsed during DATA bit 4 of a frame -> all outputs at reset values, no pulses; next clean frame 0x7E -> out_data=0x7E.
